// File: rtl/lsu_pkg.sv
// Shared types for the load/store unit.
// States, access sizes and watchdog width.
package lsu_pkg;

   typedef enum logic [1:0] {
      IDLE,
      REQ,
      WAIT,
      DONE
   } state_e;

   typedef enum logic [1:0] {
      BYTE,
      HALF,
      WORD
   } size_e;

   localparam int WD_W = 8;

   function automatic logic misaligned(
      input size_e      s,
      input logic [1:0] a
   );
      case (s)
         BYTE:    return 1'b0;
         HALF:    return a[0];
         WORD:    return |a;
         default: return 1'b1;
      endcase
   endfunction

endpackage

// File: rtl/lsu_mem_if.sv
// Data memory bus between the LSU and memory.
// Request/grant for address phase, rvalid for read data.
interface lsu_mem_if;

   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [3:0]  mem_be;
   logic [31:0] mem_wdata;
   logic        mem_gnt;
   logic        mem_rvalid;
   logic [31:0] mem_rdata;

   modport master (
      output mem_req, mem_we, mem_addr,
      output mem_be, mem_wdata,
      input  mem_gnt, mem_rvalid, mem_rdata
   );

   modport slave (
      input  mem_req, mem_we, mem_addr,
      input  mem_be, mem_wdata,
      output mem_gnt, mem_rvalid, mem_rdata
   );

endinterface

// File: rtl/lsu_align.sv
// Byte-lane steering: enables, store replication,
// load lane extraction and sign/zero extension.
module lsu_align
   import lsu_pkg::*;
(
   input  size_e       size,
   input  logic        uns,
   input  logic [1:0]  off,
   input  logic [31:0] wdata,
   input  logic [31:0] rdata_raw,
   output logic [3:0]  be,
   output logic [31:0] wdata_rep,
   output logic [31:0] rdata_ext
);

   logic [31:0] lane;

   always_comb begin
      lane      = rdata_raw >> {off, 3'b000};
      be        = 4'b1111;
      wdata_rep = wdata;
      rdata_ext = lane;
      case (size)
         BYTE: begin
            be        = 4'b0001 << off;
            wdata_rep = {4{wdata[7:0]}};
            rdata_ext = {{24{~uns & lane[7]}}, lane[7:0]};
         end
         HALF: begin
            be        = 4'b0011 << off;
            wdata_rep = {2{wdata[15:0]}};
            rdata_ext = {{16{~uns & lane[15]}}, lane[15:0]};
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: decodes one access, runs it over
// the memory bus with a watchdog, returns the result.
module load_store_unit
   import lsu_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        d_rd_e,
   input  logic        d_wr_e,
   input  logic        lb,
   input  logic        lh,
   input  logic        lw,
   input  logic        lbu,
   input  logic        lhu,
   input  logic        sb,
   input  logic        sh,
   input  logic        sw,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   output logic        stall,
   output logic [31:0] rdata,
   output logic        done,
   output logic        err,
   lsu_mem_if.master   mem
);

   localparam logic [WD_W-1:0] WD_LAST =
      WD_W'(TIMEOUT_CYCLES - 1);

   state_e          state_q, state_d;
   size_e           dsize, size_q;
   logic            duns, has_size;
   logic            access, valid;
   logic            uns_q, we_q, err_q;
   logic [31:0]     addr_q, wdata_q, rdata_q;
   logic [WD_W-1:0] wd_q;
   logic [3:0]      be;
   logic [31:0]     wdata_rep, rdata_ext;
   logic            in_req, in_wait, tmo_hit;

   always_comb begin
      dsize    = BYTE;
      duns     = 1'b0;
      has_size = 1'b0;
      if (d_rd_e) begin
         if (lw) begin
            dsize = WORD; has_size = 1'b1;
         end else if (lh | lhu) begin
            dsize = HALF; has_size = 1'b1;
            duns  = lhu;
         end else if (lb | lbu) begin
            has_size = 1'b1;
            duns     = lbu;
         end
      end else if (d_wr_e) begin
         if (sw) begin
            dsize = WORD; has_size = 1'b1;
         end else if (sh) begin
            dsize = HALF; has_size = 1'b1;
         end else if (sb) begin
            has_size = 1'b1;
         end
      end
      access = d_rd_e | d_wr_e;
      valid  = (d_rd_e ^ d_wr_e) & has_size &
               ~misaligned(dsize, addr[1:0]);
   end

   assign in_req  = state_q == REQ;
   assign in_wait = state_q == WAIT;
   // Completion in the final watchdog cycle wins.
   assign tmo_hit = (wd_q == WD_LAST) &
                    ((in_req & ~mem.mem_gnt) |
                     (in_wait & ~mem.mem_rvalid));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      stall   = 1'b0;
      case (state_q)
         IDLE: begin
            if (valid) begin
               state_d = REQ;
               stall   = 1'b1;
            end
         end
         REQ: begin
            stall = 1'b1;
            if (mem.mem_gnt)  state_d = we_q ? DONE : WAIT;
            else if (tmo_hit) state_d = DONE;
         end
         WAIT: begin
            stall = 1'b1;
            if (mem.mem_rvalid | tmo_hit) state_d = DONE;
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         addr_q  <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
         size_q  <= BYTE;
         uns_q   <= 1'b0;
         we_q    <= 1'b0;
         err_q   <= 1'b0;
         wd_q    <= '0;
      end else begin
         err_q <= 1'b0;
         if (state_q == IDLE) begin
            if (valid) begin
               addr_q  <= addr;
               wdata_q <= wdata;
               size_q  <= dsize;
               uns_q   <= duns;
               we_q    <= d_wr_e;
               wd_q    <= '0;
            end else if (access) begin
               err_q <= 1'b1;
            end
         end
         if (in_req | in_wait) wd_q <= wd_q + 1'b1;
         if (in_wait & mem.mem_rvalid) begin
            rdata_q <= rdata_ext;
         end else if (tmo_hit) begin
            rdata_q <= '0;
            err_q   <= 1'b1;
         end
      end
   end

   lsu_align u_align (
      .size      (size_q),
      .uns       (uns_q),
      .off       (addr_q[1:0]),
      .wdata     (wdata_q),
      .rdata_raw (mem.mem_rdata),
      .be        (be),
      .wdata_rep (wdata_rep),
      .rdata_ext (rdata_ext)
   );

   assign mem.mem_req   = in_req;
   assign mem.mem_we    = in_req & we_q;
   assign mem.mem_addr  = {addr_q[31:2], 2'b00};
   assign mem.mem_be    = in_req ? be : 4'b0000;
   assign mem.mem_wdata = wdata_rep;

   assign rdata = rdata_q;
   assign done  = state_q == DONE;
   assign err   = err_q;

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 Parameter: TIMEOUT_CYCLES, 255, max cycles in REQ+WAIT before abort (1..255).
REQ-002 clk  input  1  single clock; all state on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 d_rd_e / d_wr_e  input  1 each  load / store request from decode.
REQ-005 lb, lh, lw, lbu, lhu  input  1 each  load size/sign strobes from decode.
REQ-006 sb, sh, sw  input  1 each  store size strobes from decode.
REQ-007 addr  input  32  byte address from ALU.
REQ-008 wdata  input  32  store data (rs2).
REQ-009 stall  output  1  core must hold PC/instruction while high.
REQ-010 rdata  output  32  extended load result, registered, valid when done=1.
REQ-011 done  output  1  one-cycle completion pulse.
REQ-012 err  output  1  one-cycle pulse: misaligned, no size strobe, rd+wr both high, or timeout.
REQ-013 mem_req / mem_we  output  1 each  memory request / write qualifier.
REQ-014 mem_addr  output  32  word address, addr with [1:0] forced to 0.
REQ-015 mem_be / mem_wdata  output  4 / 32  byte enables / lane-replicated store data.
REQ-016 mem_gnt / mem_rvalid  input  1 each  request accepted / read data valid.
REQ-017 mem_rdata  input  32  read word.

Function
REQ-018 FSM states SHALL be IDLE, REQ, WAIT, DONE.
REQ-019 Size decode priority SHALL be word > half > byte (lw>lh|lhu>lb|lbu; sw>sh>sb); unsigned = lbu|lhu at selected size.
REQ-020 IDLE: valid access (exactly one of d_rd_e/d_wr_e, a size strobe, aligned) SHALL register addr/size/data/lanes and go to REQ; stall=1 combinationally that cycle.
REQ-021 IDLE: malformed or misaligned access (half addr[0]=1; word addr[1:0]!=0) SHALL pulse err next cycle, issue no mem_req, keep stall=0.
REQ-022 REQ: mem_req=1 with mem_we/addr/be/wdata held stable until mem_gnt=1; gnt on store -> DONE, on load -> WAIT.
REQ-023 WAIT: mem_rvalid=1 SHALL register extracted rdata and go to DONE; mem_rvalid in REQ or IDLE SHALL be ignored.
REQ-024 DONE: done=1, stall=0 for exactly one cycle, then IDLE; inputs in DONE SHALL NOT launch an access.
REQ-025 mem_be: byte 4'b0001<<addr[1:0]; half 4'b0011<<addr[1:0]; word 4'b1111.
REQ-026 mem_wdata: byte {4{wdata[7:0]}}; half {2{wdata[15:0]}}; word wdata.
REQ-027 rdata: lane = mem_rdata >> 8*addr[1:0]; byte/half sign- or zero-extended per REQ-019.
REQ-028 8-bit watchdog SHALL clear on entering REQ and count in REQ/WAIT; reaching TIMEOUT_CYCLES SHALL drop mem_req, pulse err, load rdata=0, go to DONE.
REQ-029 Latency: store >=3 cycles (IDLE, REQ+gnt, DONE); load >=4 cycles with rvalid the cycle after gnt.
REQ-030 stall SHALL be 1 in REQ and WAIT and 0 in DONE.

Reset
REQ-031 rst_n low SHALL immediately force IDLE, mem_req=0, mem_we=0, mem_addr=0, mem_be=0, mem_wdata=0, rdata=0, done=0, err=0, watchdog=0.
REQ-032 Reset mid-transaction SHALL abandon it; a later stale mem_rvalid SHALL have no effect.

Structure
REQ-033 Package lsu_pkg SHALL hold the state enum, size enum (BYTE, HALF, WORD), and watchdog width constant.
REQ-034 Combinational sub-module lsu_align SHALL compute mem_be, mem_wdata replication and rdata extraction/extension.

Verification
REQ-035 sb, addr=0x1003, wdata=0x000000A5, gnt 1st REQ cycle -> mem_be=4'b1000, mem_wdata=0xA5A5A5A5, mem_addr=0x1000, done 3rd cycle.
REQ-036 lb, addr=0x2002, mem_rdata=0x00800000, rvalid after gnt -> rdata=0xFFFFFF80; same with lbu -> 0x00000080.
REQ-037 lw, addr=0x3002 -> err pulse, no mem_req, stall=0; lh, addr=0x3001 -> same.
REQ-038 sw with gnt delayed 5 cycles -> mem_req/addr/be/wdata stable 5 cycles, stall=1 throughout, done once.
REQ-039 lw, gnt given, rvalid never, TIMEOUT_CYCLES=16 -> err and done at count 16, rdata=0.
REQ-040 rst_n low in WAIT, rvalid 2 cycles after release -> IDLE, no done, rdata stays 0.
